// File: rtl/convmax_seq_if.sv
`default_nettype none
// ============================================================================
//  Module  : convmax_seq_if
//  Brief   : Request/result bundle between a line-buffer master and the
//            convmax_seq peak finder.
//  Revision: 1.0  initial release
// ============================================================================
interface convmax_seq_if #(
    parameter int NPIX   = 120,
    parameter int TAPS   = 8,
    parameter int PIX_W  = 8,
    parameter int COEF_W = 8,
    parameter int ACC_W  = PIX_W + COEF_W + $clog2(TAPS),
    parameter int POS_W  = ((NPIX - TAPS + 1) > 1) ? $clog2(NPIX - TAPS + 1) : 1
);
    logic                     start;
    logic [NPIX*PIX_W-1:0]    indata;
    logic [TAPS*COEF_W-1:0]   gauss;
    logic [ACC_W-1:0]         threshold;
    logic                     ready;
    logic                     done;
    logic [ACC_W-1:0]         maxval;
    logic [POS_W-1:0]         maxpos;
    logic                     found;

    modport master (
        output start, indata, gauss, threshold,
        input  ready, done, maxval, maxpos, found
    );

    modport slave (
        input  start, indata, gauss, threshold,
        output ready, done, maxval, maxpos, found
    );
endinterface
`default_nettype wire

// File: rtl/convmax_seq.sv
`default_nettype none
// ============================================================================
//  Module  : convmax_seq
//  Brief   : Sequential laser-line peak finder. Slides a TAPS-wide kernel
//            across one sensor line, one window per clock, through a
//            registered MAC stage and a running-maximum compare stage.
//  Revision: 1.0  initial release
// ============================================================================
module convmax_seq #(
    parameter int NPIX   = 120,
    parameter int TAPS   = 8,
    parameter int PIX_W  = 8,
    parameter int COEF_W = 8,
    parameter int ACC_W  = PIX_W + COEF_W + $clog2(TAPS),
    parameter int POS_W  = ((NPIX - TAPS + 1) > 1) ? $clog2(NPIX - TAPS + 1) : 1
) (
    input  logic           clk,
    input  logic           reset,
    convmax_seq_if.slave   bus
);

    localparam int NWIN   = NPIX - TAPS + 1;
    localparam int IDX_W  = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam int PROD_W = PIX_W + COEF_W;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SCAN  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                w_accept;

    // Snapshot of the request taken on the accepting edge
    logic [PIX_W-1:0]    r_pix  [NPIX];
    logic [COEF_W-1:0]   r_coef [TAPS];
    logic [ACC_W-1:0]    r_thr;

    // Window issue index
    logic [POS_W-1:0]    r_k;

    // Stage 1: registered window response
    logic                r_s1_vld;
    logic [ACC_W-1:0]    r_s1_val;
    logic [POS_W-1:0]    r_s1_k;

    // Stage 2: running maximum
    logic [ACC_W-1:0]    r_max;
    logic [POS_W-1:0]    r_pos;

    // Published results
    logic [ACC_W-1:0]    r_maxval;
    logic [POS_W-1:0]    r_maxpos;
    logic                r_found;

    logic [ACC_W-1:0]    w_win;
    logic [PROD_W-1:0]   w_prod;
    logic [IDX_W-1:0]    w_idx;
    logic                w_take;
    logic [ACC_W-1:0]    w_max_nxt;
    logic [POS_W-1:0]    w_pos_nxt;

    // Next-state decode; a start is honoured in IDLE and in the DONE cycle
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_SCAN;
                end
            end
            S_SCAN: begin
                if (r_k == POS_W'(NWIN - 1)) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                w_state_nxt = S_DONE;
            end
            S_DONE: begin
                if (bus.start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_SCAN;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Window k response: sum of pixel[k+j] * coef[j]; ACC_W cannot overflow
    always_comb begin
        w_win  = '0;
        w_prod = '0;
        w_idx  = '0;
        for (int j = 0; j < TAPS; j++) begin
            w_idx  = IDX_W'(r_k) + IDX_W'(j);
            w_prod = PROD_W'(r_pix[w_idx]) * PROD_W'(r_coef[j]);
            w_win  = w_win + ACC_W'(w_prod);
        end
    end

    // Strict greater-than keeps the lowest index on ties; window 0 always loads
    always_comb begin
        w_take    = r_s1_vld && ((r_s1_k == '0) || (r_s1_val > r_max));
        w_max_nxt = w_take ? r_s1_val : r_max;
        w_pos_nxt = w_take ? r_s1_k   : r_pos;
    end

    // Request snapshot; only meaningful after an accept, so no reset needed
    always_ff @(posedge clk) begin
        if (w_accept) begin
            for (int i = 0; i < NPIX; i++) begin
                r_pix[i] <= bus.indata[i*PIX_W +: PIX_W];
            end
            for (int j = 0; j < TAPS; j++) begin
                r_coef[j] <= bus.gauss[j*COEF_W +: COEF_W];
            end
        end
    end

    // Control, pipeline and result registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_thr    <= '0;
            r_k      <= '0;
            r_s1_vld <= 1'b0;
            r_s1_val <= '0;
            r_s1_k   <= '0;
            r_max    <= '0;
            r_pos    <= '0;
            r_maxval <= '0;
            r_maxpos <= '0;
            r_found  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_s1_vld <= (r_state == S_SCAN);

            if (r_state == S_SCAN) begin
                r_s1_val <= w_win;
                r_s1_k   <= r_k;
                r_k      <= r_k + POS_W'(1);
            end

            if (w_accept) begin
                r_thr <= bus.threshold;
                r_k   <= '0;
                r_max <= '0;
                r_pos <= '0;
            end else begin
                r_max <= w_max_nxt;
                r_pos <= w_pos_nxt;
            end

            // The last compare lands on the edge entering DONE, so publish
            // the post-compare values directly
            if (r_state == S_DRAIN) begin
                r_maxval <= w_max_nxt;
                r_maxpos <= w_pos_nxt;
                r_found  <= (w_max_nxt >= r_thr);
            end
        end
    end

    assign bus.ready  = (r_state == S_IDLE) || (r_state == S_DONE);
    assign bus.done   = (r_state == S_DONE);
    assign bus.maxval = r_maxval;
    assign bus.maxpos = r_maxpos;
    assign bus.found  = r_found;

endmodule
`default_nettype wire

// File: tb/tb_convmax_seq.sv
`default_nettype none
// ============================================================================
//  Module  : tb_convmax_seq
//  Brief   : Directed self-checking bench for convmax_seq.
//  Revision: 1.0  initial release
// ============================================================================
module tb_convmax_seq;

    localparam int NPIX   = 120;
    localparam int TAPS   = 8;
    localparam int PIX_W  = 8;
    localparam int COEF_W = 8;
    localparam int ACC_W  = 19;
    localparam int POS_W  = 7;
    localparam int LAT    = 115;   // NWIN + 2 cycles, start edge counted as 1
    localparam int LIMIT  = 400;

    logic clk;
    logic rst;

    int n_checks;
    int n_errors;

    convmax_seq_if #(
        .NPIX(NPIX), .TAPS(TAPS), .PIX_W(PIX_W), .COEF_W(COEF_W),
        .ACC_W(ACC_W), .POS_W(POS_W)
    ) bus_if ();

    convmax_seq #(
        .NPIX(NPIX), .TAPS(TAPS), .PIX_W(PIX_W), .COEF_W(COEF_W),
        .ACC_W(ACC_W), .POS_W(POS_W)
    ) u_dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_all_pix(input int v);
        for (int i = 0; i < NPIX; i++) bus_if.indata[i*PIX_W +: PIX_W] = PIX_W'(v);
    endtask

    task automatic set_all_coef(input int v);
        for (int j = 0; j < TAPS; j++) bus_if.gauss[j*COEF_W +: COEF_W] = COEF_W'(v);
    endtask

    task automatic load_impulse();
        set_all_pix(0);
        bus_if.indata[50*PIX_W +: PIX_W] = 8'd200;
        set_all_coef(1);
        bus_if.threshold = 19'd100;
    endtask

    task automatic load_asym();
        set_all_pix(0);
        bus_if.indata[60*PIX_W +: PIX_W] = 8'd10;
        bus_if.indata[61*PIX_W +: PIX_W] = 8'd250;
        bus_if.indata[62*PIX_W +: PIX_W] = 8'd10;
        bus_if.gauss = {8'd1, 8'd2, 8'd4, 8'd8, 8'd8, 8'd4, 8'd2, 8'd1};
        bus_if.threshold = 19'd2120;
    endtask

    // Present start for one edge; called 1 time unit after an edge
    task automatic go();
        bus_if.start = 1'b1;
        @(posedge clk);
        #1;
        bus_if.start = 1'b0;
    endtask

    // Count cycles from the accepting edge until done is seen (bounded)
    task automatic wait_done(output int lat);
        lat = 1;
        while (!bus_if.done && lat < LIMIT) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic check_result(input string tag, input int lat,
                                input int mv, input int mp, input int fd);
        check({tag, "_latency"}, 32'(lat), 32'(LAT));
        check({tag, "_maxval"},  32'(bus_if.maxval), 32'(mv));
        check({tag, "_maxpos"},  32'(bus_if.maxpos), 32'(mp));
        check({tag, "_found"},   32'(bus_if.found),  32'(fd));
    endtask

    initial begin
        int lat;
        int ndone;
        int first_lat;

        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        bus_if.start = 1'b0;
        set_all_pix(0);
        set_all_coef(1);
        bus_if.threshold = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_ready",  32'(bus_if.ready),  32'd1);
        check("rst_done",   32'(bus_if.done),   32'd0);
        check("rst_maxval", 32'(bus_if.maxval), 32'd0);
        check("rst_maxpos", 32'(bus_if.maxpos), 32'd0);
        check("rst_found",  32'(bus_if.found),  32'd0);

        // All-zero line, threshold 0: 0 >= 0 so found
        go();
        check("zero_busy", 32'(bus_if.ready), 32'd0);
        wait_done(lat);
        check_result("zero", lat, 0, 0, 1);
        check("zero_done_ready", 32'(bus_if.ready), 32'd1);
        @(posedge clk);
        #1;
        check("zero_done_pulse", 32'(bus_if.done), 32'd0);

        // Impulse of 200 at pixel 50: windows 43..50 all equal 200, lowest kept
        load_impulse();
        go();
        wait_done(lat);
        check_result("impulse", lat, 200, 43, 1);

        // Saturation: 8 * 255 * 255 = 520200; one above threshold misses
        set_all_pix(255);
        set_all_coef(255);
        bus_if.threshold = 19'd520201;
        go();
        wait_done(lat);
        check_result("sat_miss", lat, 520200, 0, 0);
        repeat (10) @(posedge clk);
        #1;
        check("sat_hold_maxval", 32'(bus_if.maxval), 32'd520200);

        // Threshold exactly equal to the peak counts as found
        bus_if.threshold = 19'd520200;
        go();
        wait_done(lat);
        check_result("sat_equal", lat, 520200, 0, 1);

        // Asymmetric peak: win[57] = 10*8 + 250*8 + 10*4 = 2120,
        // win[58] = 10*4 + 250*8 + 10*8 = 2120, lowest index 57 kept.
        // Inputs are scrambled after the accepting edge and must not matter.
        load_asym();
        go();
        set_all_pix(255);
        bus_if.threshold = 19'h7FFFF;
        wait_done(lat);
        check_result("asym", lat, 2120, 57, 1);

        // Start pulsed mid-scan is ignored; exactly one done
        load_impulse();
        go();
        ndone = 0;
        first_lat = 0;
        for (int c = 2; c <= 260; c++) begin
            if (c == 20) begin
                set_all_pix(255);
                bus_if.start = 1'b1;
            end
            if (c == 21) bus_if.start = 1'b0;
            @(posedge clk);
            #1;
            if (bus_if.done) begin
                ndone++;
                if (first_lat == 0) first_lat = c;
            end
        end
        check("ignore_ndone",   32'(ndone),     32'd1);
        check("ignore_latency", 32'(first_lat), 32'(LAT));
        check("ignore_maxval",  32'(bus_if.maxval), 32'd200);

        // Back-to-back: start in the DONE cycle of an impulse scan
        load_impulse();
        go();
        wait_done(lat);
        check_result("b2b_first", lat, 200, 43, 1);
        load_asym();
        go();
        wait_done(lat);
        check_result("b2b_second", lat, 2120, 57, 1);

        // Reset partway through a scan abandons it
        set_all_pix(255);
        set_all_coef(255);
        bus_if.threshold = 19'd0;
        go();
        repeat (58) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midrst_ready",  32'(bus_if.ready),  32'd1);
        check("midrst_maxval", 32'(bus_if.maxval), 32'd0);
        check("midrst_maxpos", 32'(bus_if.maxpos), 32'd0);
        check("midrst_found",  32'(bus_if.found),  32'd0);
        ndone = 0;
        for (int c = 0; c < 200; c++) begin
            @(posedge clk);
            #1;
            if (bus_if.done) ndone++;
        end
        check("midrst_no_done", 32'(ndone), 32'd0);

        // A fresh scan after the abandoned one completes normally
        load_impulse();
        go();
        wait_done(lat);
        check_result("after_rst", lat, 200, 43, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
